// File: rtl/ascii_scancode_tx.sv
// ascii_scancode_tx: encodes one ASCII character into the PS/2 Set-2 byte
// stream a keyboard would send for it. The stream is the make code, then the
// break codes when EMIT_BREAK is set. Shifted characters are wrapped in
// SHIFT_CODE make/break bytes.
//
// state       | meaning
// ------------+-------------------------------------------
// IDLE        | ready for a character, no byte pending
// SH_MAKE     | presenting SHIFT_CODE (shift make)
// MAKE        | presenting the character make code
// BRK_F0      | presenting F0 prefix of the character break
// BRK_CODE    | presenting the character code (break)
// SH_BRK_F0   | presenting F0 prefix of the shift break
// SH_BRK_CODE | presenting SHIFT_CODE (shift break)
module ascii_scancode_tx #(
  parameter logic [7:0] SHIFT_CODE = 8'h12,
  parameter bit         EMIT_BREAK = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ascii_in,
  input  logic       ascii_valid,
  output logic       ascii_ready,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       unsupported
);

  typedef enum logic [2:0] {
    IDLE, SH_MAKE, MAKE, BRK_F0, BRK_CODE, SH_BRK_F0, SH_BRK_CODE
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] code_q;
  logic       shift_q;
  logic [7:0] lk_code;
  logic       lk_shift;
  logic       lk_hit;
  logic       is_letter;
  logic       accept;
  logic       byte_hs;

  // Letter codes indexed by the low five bits of the ASCII value ('a'/'A' = 1).
  function automatic logic [7:0] letter_code(input logic [4:0] idx);
    case (idx)
      5'd1:    letter_code = 8'h1C;
      5'd2:    letter_code = 8'h32;
      5'd3:    letter_code = 8'h21;
      5'd4:    letter_code = 8'h23;
      5'd5:    letter_code = 8'h24;
      5'd6:    letter_code = 8'h2B;
      5'd7:    letter_code = 8'h34;
      5'd8:    letter_code = 8'h33;
      5'd9:    letter_code = 8'h43;
      5'd10:   letter_code = 8'h3B;
      5'd11:   letter_code = 8'h42;
      5'd12:   letter_code = 8'h4B;
      5'd13:   letter_code = 8'h3A;
      5'd14:   letter_code = 8'h31;
      5'd15:   letter_code = 8'h44;
      5'd16:   letter_code = 8'h4D;
      5'd17:   letter_code = 8'h15;
      5'd18:   letter_code = 8'h2D;
      5'd19:   letter_code = 8'h1B;
      5'd20:   letter_code = 8'h2C;
      5'd21:   letter_code = 8'h3C;
      5'd22:   letter_code = 8'h2A;
      5'd23:   letter_code = 8'h1D;
      5'd24:   letter_code = 8'h22;
      5'd25:   letter_code = 8'h35;
      5'd26:   letter_code = 8'h1A;
      default: letter_code = 8'h00;
    endcase
  endfunction

  // 0x41-0x5A and 0x61-0x7A differ only in bit 5, which is the inverse of shift.
  assign is_letter = (ascii_in[7:6] == 2'b01) && (ascii_in[4:0] >= 5'd1) &&
                     (ascii_in[4:0] <= 5'd26);
  assign accept    = ascii_valid && ascii_ready;
  assign byte_hs   = byte_valid && byte_ready;

  // Combinational character lookup: {code, shift, hit}.
  always_comb begin
    lk_code  = 8'h00;
    lk_shift = 1'b0;
    lk_hit   = 1'b1;
    if (is_letter) begin
      lk_code  = letter_code(ascii_in[4:0]);
      lk_shift = ~ascii_in[5];
    end else begin
      case (ascii_in)
        8'h30: {lk_code, lk_shift} = {8'h45, 1'b0};
        8'h29: {lk_code, lk_shift} = {8'h45, 1'b1};
        8'h31: {lk_code, lk_shift} = {8'h16, 1'b0};
        8'h21: {lk_code, lk_shift} = {8'h16, 1'b1};
        8'h32: {lk_code, lk_shift} = {8'h1E, 1'b0};
        8'h40: {lk_code, lk_shift} = {8'h1E, 1'b1};
        8'h33: {lk_code, lk_shift} = {8'h26, 1'b0};
        8'h23: {lk_code, lk_shift} = {8'h26, 1'b1};
        8'h34: {lk_code, lk_shift} = {8'h25, 1'b0};
        8'h24: {lk_code, lk_shift} = {8'h25, 1'b1};
        8'h35: {lk_code, lk_shift} = {8'h2E, 1'b0};
        8'h25: {lk_code, lk_shift} = {8'h2E, 1'b1};
        8'h36: {lk_code, lk_shift} = {8'h36, 1'b0};
        8'h5E: {lk_code, lk_shift} = {8'h36, 1'b1};
        8'h37: {lk_code, lk_shift} = {8'h3D, 1'b0};
        8'h26: {lk_code, lk_shift} = {8'h3D, 1'b1};
        8'h38: {lk_code, lk_shift} = {8'h3E, 1'b0};
        8'h2A: {lk_code, lk_shift} = {8'h3E, 1'b1};
        8'h39: {lk_code, lk_shift} = {8'h46, 1'b0};
        8'h28: {lk_code, lk_shift} = {8'h46, 1'b1};
        8'h60: {lk_code, lk_shift} = {8'h0E, 1'b0};
        8'h7E: {lk_code, lk_shift} = {8'h0E, 1'b1};
        8'h2D: {lk_code, lk_shift} = {8'h4E, 1'b0};
        8'h5F: {lk_code, lk_shift} = {8'h4E, 1'b1};
        8'h3D: {lk_code, lk_shift} = {8'h55, 1'b0};
        8'h2B: {lk_code, lk_shift} = {8'h55, 1'b1};
        8'h5C: {lk_code, lk_shift} = {8'h5D, 1'b0};
        8'h7C: {lk_code, lk_shift} = {8'h5D, 1'b1};
        8'h5B: {lk_code, lk_shift} = {8'h54, 1'b0};
        8'h7B: {lk_code, lk_shift} = {8'h54, 1'b1};
        8'h5D: {lk_code, lk_shift} = {8'h5B, 1'b0};
        8'h7D: {lk_code, lk_shift} = {8'h5B, 1'b1};
        8'h3B: {lk_code, lk_shift} = {8'h4C, 1'b0};
        8'h3A: {lk_code, lk_shift} = {8'h4C, 1'b1};
        8'h27: {lk_code, lk_shift} = {8'h52, 1'b0};
        8'h22: {lk_code, lk_shift} = {8'h52, 1'b1};
        8'h2C: {lk_code, lk_shift} = {8'h41, 1'b0};
        8'h3C: {lk_code, lk_shift} = {8'h41, 1'b1};
        8'h2E: {lk_code, lk_shift} = {8'h49, 1'b0};
        8'h3E: {lk_code, lk_shift} = {8'h49, 1'b1};
        8'h2F: {lk_code, lk_shift} = {8'h4A, 1'b0};
        8'h3F: {lk_code, lk_shift} = {8'h4A, 1'b1};
        8'h20: {lk_code, lk_shift} = {8'h29, 1'b0};
        8'h08: {lk_code, lk_shift} = {8'h66, 1'b0};
        8'h09: {lk_code, lk_shift} = {8'h0D, 1'b0};
        8'h0D: {lk_code, lk_shift} = {8'h5A, 1'b0};
        8'h1B: {lk_code, lk_shift} = {8'h76, 1'b0};
        default: lk_hit = 1'b0;
      endcase
    end
  end

  // State register, latched character and unsupported pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      code_q      <= 8'h00;
      shift_q     <= 1'b0;
      unsupported <= 1'b0;
    end else begin
      state       <= state_nxt;
      unsupported <= accept && !lk_hit;
      if (accept && lk_hit) begin
        code_q  <= lk_code;
        shift_q <= lk_shift;
      end
    end
  end

  // Next-state: advance on accept from IDLE or on each byte handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (accept && lk_hit) state_nxt = lk_shift ? SH_MAKE : MAKE;
      SH_MAKE:     if (byte_hs) state_nxt = MAKE;
      MAKE:        if (byte_hs) state_nxt = EMIT_BREAK ? BRK_F0 : IDLE;
      BRK_F0:      if (byte_hs) state_nxt = BRK_CODE;
      BRK_CODE:    if (byte_hs) state_nxt = shift_q ? SH_BRK_F0 : IDLE;
      SH_BRK_F0:   if (byte_hs) state_nxt = SH_BRK_CODE;
      SH_BRK_CODE: if (byte_hs) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  // Outputs are a pure function of state, so they hold while stalled.
  always_comb begin
    ascii_ready = (state == IDLE);
    byte_valid  = (state != IDLE);
    byte_out    = 8'h00;
    case (state)
      SH_MAKE:     byte_out = SHIFT_CODE;
      MAKE:        byte_out = code_q;
      BRK_F0:      byte_out = 8'hF0;
      BRK_CODE:    byte_out = code_q;
      SH_BRK_F0:   byte_out = 8'hF0;
      SH_BRK_CODE: byte_out = SHIFT_CODE;
      default:     byte_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_ascii_scancode_tx.sv
// Directed bench for ascii_scancode_tx: instance u_dut emits breaks,
// instance u_nobrk has EMIT_BREAK=0. All sampling and driving is done
// on the falling clock edge.
module tb_ascii_scancode_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] ascii_in = 8'h00;
  logic       ascii_valid = 1'b0;
  logic       ascii_ready;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready = 1'b1;
  logic       unsupported;

  logic [7:0] b_ascii_in = 8'h00;
  logic       b_ascii_valid = 1'b0;
  logic       b_ascii_ready;
  logic [7:0] b_byte_out;
  logic       b_byte_valid;
  logic       b_byte_ready = 1'b1;
  logic       b_unsupported;

  int errors = 0;
  int checks = 0;

  logic [7:0] cap [16];
  int         cap_n;
  int         cap_lat;
  logic       cap_rdy_before;
  logic       cap_rdy_after;
  logic       cap_timeout;

  always #5 clk = ~clk;

  ascii_scancode_tx #(.SHIFT_CODE(8'h12), .EMIT_BREAK(1'b1)) u_dut (
    .clk(clk), .reset(reset), .ascii_in(ascii_in), .ascii_valid(ascii_valid),
    .ascii_ready(ascii_ready), .byte_out(byte_out), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .unsupported(unsupported)
  );

  ascii_scancode_tx #(.SHIFT_CODE(8'h12), .EMIT_BREAK(1'b0)) u_nobrk (
    .clk(clk), .reset(reset), .ascii_in(b_ascii_in), .ascii_valid(b_ascii_valid),
    .ascii_ready(b_ascii_ready), .byte_out(b_byte_out), .byte_valid(b_byte_valid),
    .byte_ready(b_byte_ready), .unsupported(b_unsupported)
  );

  // Stimulus only: offer one character with byte_ready held high and record
  // every byte presented until byte_valid drops again.
  task automatic capture(input bit sel, input logic [7:0] c);
    logic v;
    cap_n = 0; cap_lat = -1; cap_timeout = 1'b1; cap_rdy_after = 1'b0;
    @(negedge clk);
    cap_rdy_before = sel ? b_ascii_ready : ascii_ready;
    if (sel) begin b_ascii_in = c; b_ascii_valid = 1'b1; b_byte_ready = 1'b1; end
    else     begin ascii_in = c;   ascii_valid = 1'b1;   byte_ready = 1'b1;   end
    @(negedge clk);
    ascii_valid = 1'b0; b_ascii_valid = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      v = sel ? b_byte_valid : byte_valid;
      if (v) begin
        if (cap_lat < 0) cap_lat = cyc;
        if (cap_n < 16) cap[cap_n] = sel ? b_byte_out : byte_out;
        cap_n++;
      end else if (cap_n > 0) begin
        cap_timeout = 1'b0;
        cap_rdy_after = sel ? b_ascii_ready : ascii_ready;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (byte_valid !== 1'b0 || byte_out !== 8'h00 || unsupported !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b out=%h unsup=%b, want 0 00 0",
               byte_valid, byte_out, unsupported);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (ascii_ready !== 1'b1 || b_ascii_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: ready=%b/%b, want 1/1", ascii_ready, b_ascii_ready);
    end
  endtask

  task automatic test_unshifted();
    logic [7:0] exp [3] = '{8'h1C, 8'hF0, 8'h1C};
    capture(1'b0, 8'h61);
    checks++;
    if (cap_timeout !== 1'b0 || cap_n !== 3) begin
      errors++;
      $display("FAIL a_count: n=%0d timeout=%b, want 3 0", cap_n, cap_timeout);
    end
    checks++;
    if (cap_lat !== 1) begin
      errors++;
      $display("FAIL a_latency: got %0d, want 1", cap_lat);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cap[i] !== exp[i]) begin
        errors++;
        $display("FAIL a_byte%0d: got %h, want %h", i, cap[i], exp[i]);
      end
    end
    checks++;
    if (cap_rdy_before !== 1'b1 || cap_rdy_after !== 1'b1) begin
      errors++;
      $display("FAIL a_ready: before=%b after=%b, want 1 1", cap_rdy_before, cap_rdy_after);
    end
  endtask

  task automatic test_shifted();
    logic [7:0] chars [2] = '{8'h41, 8'h3F};
    logic [7:0] codes [2] = '{8'h1C, 8'h4A};
    logic [7:0] exp [6];
    for (int k = 0; k < 2; k++) begin
      exp = '{8'h12, codes[k], 8'hF0, codes[k], 8'hF0, 8'h12};
      capture(1'b0, chars[k]);
      checks++;
      if (cap_timeout !== 1'b0 || cap_n !== 6 || cap_rdy_after !== 1'b1) begin
        errors++;
        $display("FAIL shift_count_%h: n=%0d timeout=%b rdy=%b, want 6 0 1",
                 chars[k], cap_n, cap_timeout, cap_rdy_after);
      end
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (cap[i] !== exp[i]) begin
          errors++;
          $display("FAIL shift_%h_byte%0d: got %h, want %h", chars[k], i, cap[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_table();
    logic [7:0] chars [14] = '{8'h30, 8'h21, 8'h7E, 8'h5C, 8'h3A, 8'h22, 8'h08,
                              8'h09, 8'h1B, 8'h6D, 8'h51, 8'h7D, 8'h3C, 8'h2D};
    logic [7:0] codes [14] = '{8'h45, 8'h16, 8'h0E, 8'h5D, 8'h4C, 8'h52, 8'h66,
                              8'h0D, 8'h76, 8'h3A, 8'h15, 8'h5B, 8'h41, 8'h4E};
    logic       shf   [14] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    int         n_exp;
    int         pos;
    for (int k = 0; k < 14; k++) begin
      capture(1'b0, chars[k]);
      n_exp = shf[k] ? 6 : 3;
      pos   = shf[k] ? 1 : 0;
      checks++;
      if (cap_n !== n_exp || cap[pos] !== codes[k] || cap[0] !== (shf[k] ? 8'h12 : codes[k])) begin
        errors++;
        $display("FAIL table_%h: n=%0d first=%h code=%h, want n=%0d code=%h",
                 chars[k], cap_n, cap[0], cap[pos], n_exp, codes[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic       rdy [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] exp [6] = '{8'h24, 8'hF0, 8'hF0, 8'hF0, 8'h24, 8'h24};
    @(negedge clk);
    ascii_in = 8'h65; ascii_valid = 1'b1; byte_ready = 1'b1;
    @(negedge clk);
    ascii_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      byte_ready = rdy[i];
      checks++;
      if (byte_valid !== 1'b1 || byte_out !== exp[i] || ascii_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_cycle%0d: valid=%b out=%h ready=%b, want 1 %h 0",
                 i, byte_valid, byte_out, ascii_ready, exp[i]);
      end
      @(negedge clk);
    end
    byte_ready = 1'b1;
    checks++;
    if (byte_valid !== 1'b0 || ascii_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_end: valid=%b ready=%b, want 0 1", byte_valid, ascii_ready);
    end
  endtask

  task automatic test_unsupported();
    logic [7:0] chars [2] = '{8'h80, 8'h7F};
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      ascii_in = chars[k]; ascii_valid = 1'b1;
      @(negedge clk);
      ascii_valid = 1'b0;
      checks++;
      if (unsupported !== 1'b1 || byte_valid !== 1'b0 || ascii_ready !== 1'b1) begin
        errors++;
        $display("FAIL unsup_%h_pulse: unsup=%b valid=%b ready=%b, want 1 0 1",
                 chars[k], unsupported, byte_valid, ascii_ready);
      end
      @(negedge clk);
      checks++;
      if (unsupported !== 1'b0 || byte_valid !== 1'b0 || ascii_ready !== 1'b1) begin
        errors++;
        $display("FAIL unsup_%h_after: unsup=%b valid=%b ready=%b, want 0 0 1",
                 chars[k], unsupported, byte_valid, ascii_ready);
      end
    end
  endtask

  task automatic test_no_break();
    capture(1'b1, 8'h25);
    checks++;
    if (cap_n !== 2 || cap[0] !== 8'h12 || cap[1] !== 8'h2E || cap_rdy_after !== 1'b1) begin
      errors++;
      $display("FAIL nobrk_pct: n=%0d bytes=%h %h rdy=%b, want 2 12 2E 1",
               cap_n, cap[0], cap[1], cap_rdy_after);
    end
    capture(1'b1, 8'h0D);
    checks++;
    if (cap_n !== 1 || cap[0] !== 8'h5A || cap_rdy_after !== 1'b1) begin
      errors++;
      $display("FAIL nobrk_cr: n=%0d byte=%h rdy=%b, want 1 5A 1", cap_n, cap[0], cap_rdy_after);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp [3] = '{8'h29, 8'hF0, 8'h29};
    @(negedge clk);
    ascii_in = 8'h5A; ascii_valid = 1'b1; byte_ready = 1'b1;
    @(negedge clk);
    ascii_valid = 1'b0;
    checks++;
    if (byte_out !== 8'h12) begin
      errors++;
      $display("FAIL rmid_b0: got %h, want 12", byte_out);
    end
    @(negedge clk);
    checks++;
    if (byte_out !== 8'h1A) begin
      errors++;
      $display("FAIL rmid_b1: got %h, want 1A", byte_out);
    end
    @(negedge clk);
    byte_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    byte_ready = 1'b1;
    checks++;
    if (byte_valid !== 1'b0 || byte_out !== 8'h00) begin
      errors++;
      $display("FAIL rmid_abort: valid=%b out=%h, want 0 00", byte_valid, byte_out);
    end
    @(negedge clk);
    checks++;
    if (byte_valid !== 1'b0 || ascii_ready !== 1'b1) begin
      errors++;
      $display("FAIL rmid_idle: valid=%b ready=%b, want 0 1", byte_valid, ascii_ready);
    end
    capture(1'b0, 8'h20);
    checks++;
    if (cap_n !== 3) begin
      errors++;
      $display("FAIL rmid_space_count: n=%0d, want 3", cap_n);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cap[i] !== exp[i]) begin
        errors++;
        $display("FAIL rmid_space_byte%0d: got %h, want %h", i, cap[i], exp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unshifted();
    test_shifted();
    test_table();
    test_backpressure();
    test_unsupported();
    test_no_break();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
